halftone_frame_sequencer: RTL and testbench

- Frame controller for the error-diffusion halftone datapath.
- Fetches a 6x8 frame of 8-bit grey pixels from pixel memory in raster order: pixel_1..pixel_48, address 0..47.
- Hands each pixel to one shared halftone processing element (PE) through a req/ack handshake.
- Assembles the returned halftone bits into the six HTPV row words. Signals frame completion, PE timeout or abort.

---
 rtl/halftone_frame_sequencer_pkg.sv | 24 ++
 rtl/halftone_frame_sequencer_pixel_index_counter.sv | 42 ++++
 rtl/halftone_frame_sequencer.sv | 147 ++++++++++++++
 tb/tb_halftone_frame_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/halftone_frame_sequencer_pkg.sv
// Shared constants and types for the halftone frame sequencer.
//   ROWS x COLS frame of PIX_W-bit grey pixels, raster-ordered addresses.
//   PE_TIMEOUT bounds how long a PE request may wait for its ack.
package halftone_frame_sequencer_pkg;

  localparam int ROWS       = 6;
  localparam int COLS       = 8;
  localparam int PIX_W      = 8;
  localparam int PE_TIMEOUT = 16;

  localparam int ADDR_W = 6;
  localparam int ROW_W  = 3;
  localparam int COL_W  = 3;
  localparam int WAIT_W = $clog2(PE_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    REQ   = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/halftone_frame_sequencer_pixel_index_counter.sv
// Raster index of the pixel currently being processed.
//   clr   : return to pixel (0,0)
//   adv   : step one pixel; col wraps COLS-1 -> 0 and bumps row
//   row/col : current index, last : index is the final pixel of the frame
//   addr  : pixel memory address row*COLS+col
module pixel_index_counter
  import halftone_frame_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              adv,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col,
  output logic              last,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (adv) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign last = (row == ROW_MAX) && (col == COL_MAX);
  assign addr = ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);

endmodule

// File: rtl/halftone_frame_sequencer.sv
// Frame controller for the error-diffusion halftone datapath.
// Walks a ROWS x COLS frame in raster order: read pixel (FETCH), latch it
// (LOAD), hand it to the shared PE and wait for ack (REQ), then store the
// returned halftone bit into the HTPV row registers.
//   clock, reset    : clock, async active-low reset
//   start/abort     : begin frame (IDLE only) / drop back to IDLE
//   busy/done/err   : not-idle, one-cycle completion pulse, sticky PE timeout
//   pix_rd/pix_addr/pix_data : pixel memory port, data one cycle after rd
//   pe_req/pe_pixel/pe_row/pe_col/pe_ack/pe_bit : PE handshake
//   HTPV_Row_1..6   : halftone rows, element [c+1] is the bit for column c
module halftone_frame_sequencer
  import halftone_frame_sequencer_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              pix_rd,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              pe_req,
  output logic [PIX_W-1:0]  pe_pixel,
  output logic [ROW_W-1:0]  pe_row,
  output logic [COL_W-1:0]  pe_col,
  input  logic              pe_ack,
  input  logic              pe_bit,
  output logic [1:COLS]     HTPV_Row_1,
  output logic [1:COLS]     HTPV_Row_2,
  output logic [1:COLS]     HTPV_Row_3,
  output logic [1:COLS]     HTPV_Row_4,
  output logic [1:COLS]     HTPV_Row_5,
  output logic [1:COLS]     HTPV_Row_6
);

  state_t state, nxt;

  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic              last;
  logic              idx_clr, idx_adv;
  logic [WAIT_W-1:0] wait_cnt;
  logic              accept, take, tmo;
  logic [COL_W-1:0]  col_pos;

  // ht[r] packs row r MSB-first so that element [1] of the output row
  // (column 0) lands on the MSB.
  logic [ROWS-1:0][COLS-1:0] ht;

  pixel_index_counter u_idx (
    .clk   (clock),
    .rst_n (reset),
    .clr   (idx_clr),
    .adv   (idx_adv),
    .row   (row),
    .col   (col),
    .last  (last),
    .addr  (pix_addr)
  );

  // abort outranks both ack and timeout, so both are qualified with it.
  assign accept  = (state == IDLE) && start;
  assign take    = (state == REQ) && pe_ack && !abort;
  assign tmo     = (state == REQ) && !pe_ack && !abort &&
                   (wait_cnt == WAIT_W'(PE_TIMEOUT - 1));
  assign col_pos = COL_W'(COLS - 1) - col;

  always_comb begin
    nxt     = state;
    idx_clr = 1'b0;
    idx_adv = 1'b0;
    case (state)
      IDLE:  if (start) begin
               nxt     = FETCH;
               idx_clr = 1'b1;
             end
      FETCH: nxt = LOAD;
      LOAD:  nxt = REQ;
      REQ:   if (pe_ack) begin
               if (last) nxt = DONE;
               else begin
                 nxt     = FETCH;
                 idx_adv = 1'b1;
               end
             end else if (tmo) begin
               nxt = IDLE;
             end
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (abort && state != IDLE) begin
      nxt     = IDLE;
      idx_adv = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  // Zero outside REQ, so it is already clear on the first REQ cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                     wait_cnt <= '0;
    else if (state != REQ)          wait_cnt <= '0;
    else if (!pe_ack)               wait_cnt <= wait_cnt + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      err <= 1'b0;
    else if (accept) err <= 1'b0;
    else if (tmo)    err <= 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pe_pixel <= '0;
      pe_row   <= '0;
      pe_col   <= '0;
    end else if (state == LOAD) begin
      pe_pixel <= pix_data;
      pe_row   <= row;
      pe_col   <= col;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      ht <= '0;
    else if (accept) ht <= '0;
    else if (take)   ht[row][col_pos] <= pe_bit;
  end

  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign pix_rd = (state == FETCH);
  assign pe_req = (state == REQ);

  assign HTPV_Row_1 = ht[0];
  assign HTPV_Row_2 = ht[1];
  assign HTPV_Row_3 = ht[2];
  assign HTPV_Row_4 = ht[3];
  assign HTPV_Row_5 = ht[4];
  assign HTPV_Row_6 = ht[5];

endmodule

// File: tb/tb_halftone_frame_sequencer.sv
// Directed bench for halftone_frame_sequencer: pixel memory model, simple PE
// model with selectable ack behaviour, immediate-assertion checks.
module tb_halftone_frame_sequencer;

  logic       clock = 1'b0;
  logic       reset, start, abort;
  logic       busy, done, err, pix_rd;
  logic [5:0] pix_addr;
  logic [7:0] pix_data;
  logic       pe_req, pe_ack, pe_bit;
  logic [7:0] pe_pixel;
  logic [2:0] pe_row, pe_col;
  logic [1:8] r1, r2, r3, r4, r5, r6;

  int checks = 0;
  int fails  = 0;

  logic [7:0] mem [0:47];
  int         ack_mode = 0;   // 0 immediate, 1 after 5 cycles, 2 never for addr 19
  int         req_age  = 0;

  always #5 clock = ~clock;

  halftone_frame_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .busy(busy), .done(done), .err(err),
    .pix_rd(pix_rd), .pix_addr(pix_addr), .pix_data(pix_data),
    .pe_req(pe_req), .pe_pixel(pe_pixel), .pe_row(pe_row), .pe_col(pe_col),
    .pe_ack(pe_ack), .pe_bit(pe_bit),
    .HTPV_Row_1(r1), .HTPV_Row_2(r2), .HTPV_Row_3(r3),
    .HTPV_Row_4(r4), .HTPV_Row_5(r5), .HTPV_Row_6(r6)
  );

  // Pixel memory: data appears the cycle after the read strobe.
  always @(posedge clock) if (pix_rd) pix_data <= mem[pix_addr];

  // PE model.
  always @(posedge clock) req_age <= pe_req ? req_age + 1 : 0;
  assign pe_bit = (pe_pixel >= 8'd128);
  assign pe_ack = pe_req && ((ack_mode == 0) ||
                             (ack_mode == 1 && req_age >= 5) ||
                             (ack_mode == 2 && {pe_row, pe_col} != 6'd19));

  // Sequence / stability monitors.
  logic       mon_en = 1'b0;
  int         rd_idx = 0, pe_idx = 0, addr_bad = 0, pe_bad = 0, stab_bad = 0;
  int         done_cnt = 0;
  logic       prev_req = 1'b0, prev_wait = 1'b0;
  logic [7:0] prev_pix = '0;

  always @(negedge clock) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    prev_req  <= pe_req;
    prev_wait <= pe_req && !pe_ack;
    prev_pix  <= pe_pixel;
    if (mon_en) begin
      if (pix_rd === 1'b1) begin
        if (pix_addr !== 6'(rd_idx)) addr_bad <= addr_bad + 1;
        rd_idx <= rd_idx + 1;
      end
      if (pe_req === 1'b1 && prev_req !== 1'b1) begin
        if (pe_row !== 3'(pe_idx / 8) || pe_col !== 3'(pe_idx % 8)) pe_bad <= pe_bad + 1;
        pe_idx <= pe_idx + 1;
      end
      if (prev_wait && !(pe_req === 1'b1 && pe_pixel === prev_pix))
        stab_bad <= stab_bad + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] rows();
    return {r1, r2, r3, r4, r5, r6};
  endfunction

  task automatic load_blocks();
    for (int i = 0; i < 48; i++) begin
      int p;
      p = i + 1;
      mem[i] = ((p >= 1 && p <= 4) || (p >= 9 && p <= 12) || (p >= 17 && p <= 20) ||
                (p >= 29 && p <= 32) || (p >= 37 && p <= 40) || (p >= 45 && p <= 48))
               ? 8'd255 : 8'd0;
    end
  endtask

  task automatic load_grad();
    for (int i = 0; i < 48; i++) mem[i] = 8'(32 * (i % 8) + 31);
  endtask

  task automatic do_start();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  // Counts negedges after the start-sampling edge until done; optionally
  // pokes start while busy. Checks latency and the one-cycle pulse.
  task automatic wait_done(input string tag, input int exp, input bit poke);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
      start = poke && (n % 40 == 10);
    end while (done !== 1'b1 && n < 2000);
    start = 1'b0;
    chk({tag, "_latency"}, 64'(n), 64'(exp));
    @(negedge clock);
    chk({tag, "_pulse_end"}, {done, busy}, 2'b00);
  endtask

  task automatic wait_req_addr(input string tag, input logic [5:0] a);
    int n;
    n = 0;
    while (!(pe_req === 1'b1 && pix_addr === a) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_reached"}, 64'(n < 2000), 64'd1);
  endtask

  localparam logic [47:0] BLOCK_ROWS = {8'hF0, 8'hF0, 8'hF0, 8'h0F, 8'h0F, 8'h0F};
  localparam logic [47:0] GRAD_ROWS  = {6{8'h0F}};

  initial begin
    int d0;
    reset = 1'b0; start = 1'b0; abort = 1'b0; pix_data = '0;
    load_blocks();
    #12;
    chk("reset_outs", {busy, done, err, pix_rd, pe_req, pix_addr, pe_pixel, pe_row, pe_col},
        '0);
    chk("reset_rows", rows(), '0);
    @(negedge clock) reset = 1'b1;

    // 1: left/right blocks, immediate ack
    d0 = done_cnt;
    do_start();
    chk("t1_busy", busy, 1'b1);
    wait_done("t1", 145, 1'b0);
    chk("t1_rows", rows(), BLOCK_ROWS);
    chk("t1_one_done", 64'(done_cnt - d0), 64'd1);

    // 2: graduated pattern, address / index sequence
    load_grad();
    rd_idx = 0; pe_idx = 0; addr_bad = 0; pe_bad = 0; stab_bad = 0;
    mon_en = 1'b1;
    do_start();
    wait_done("t2", 145, 1'b0);
    mon_en = 1'b0;
    chk("t2_rows", rows(), GRAD_ROWS);
    chk("t2_reads", 64'(rd_idx), 64'd48);
    chk("t2_addr_order", 64'(addr_bad), 64'd0);
    chk("t2_pe_count", 64'(pe_idx), 64'd48);
    chk("t2_pe_rowcol", 64'(pe_bad), 64'd0);

    // 3: PE acks 5 cycles after request rise
    load_blocks();
    ack_mode = 1;
    rd_idx = 0; pe_idx = 0; stab_bad = 0;
    mon_en = 1'b1;
    do_start();
    wait_done("t3", 385, 1'b0);
    mon_en = 1'b0;
    chk("t3_stable_req", 64'(stab_bad), 64'd0);
    chk("t3_rows", rows(), BLOCK_ROWS);

    // 4: PE never acks addr 19 -> timeout after 16 REQ cycles
    ack_mode = 2;
    d0 = done_cnt;
    do_start();
    wait_req_addr("t4", 6'd19);
    repeat (15) @(negedge clock);
    chk("t4_req_cycle16", {pe_req, err}, 2'b10);
    @(negedge clock);
    chk("t4_timeout", {err, busy, pe_req}, 3'b100);
    chk("t4_rows", rows(), {8'hF0, 8'hF0, 8'hE0, 8'h00, 8'h00, 8'h00});
    chk("t4_no_done", 64'(done_cnt - d0), 64'd0);
    ack_mode = 0;
    do_start();
    chk("t4_err_cleared", {err, busy}, 2'b01);
    wait_done("t4b", 145, 1'b0);
    chk("t4b_rows", rows(), BLOCK_ROWS);

    // 5: abort on pixel 10 (ack present, abort wins), starts while busy
    d0 = done_cnt;
    do_start();
    wait_req_addr("t5", 6'd9);
    abort = 1'b1;
    @(posedge clock);
    #1 abort = 1'b0;
    @(negedge clock);
    chk("t5_abort_idle", {busy, done, err, pe_req}, 4'b0000);
    chk("t5_partial_rows", rows(), {8'hF0, 8'h80, 32'h0});
    chk("t5_no_done", 64'(done_cnt - d0), 64'd0);
    do_start();
    wait_done("t5b", 145, 1'b1);
    chk("t5b_rows", rows(), BLOCK_ROWS);

    // 6: asynchronous reset in the middle of a REQ
    ack_mode = 1;
    do_start();
    wait_req_addr("t6", 6'd2);
    chk("t6_pre_row1", r1, 8'hC0);
    #2 reset = 1'b0;
    #1;
    chk("t6_async_clear", {pe_req, busy, done, err}, 4'b0000);
    chk("t6_rows_clear", rows(), '0);
    @(negedge clock) reset = 1'b1;
    ack_mode = 0;
    load_grad();
    do_start();
    wait_done("t6b", 145, 1'b0);
    chk("t6b_rows", rows(), GRAD_ROWS);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
